// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter and its round-robin picker.
package alu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid requester after last_i, wrapping modulo N.
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int            j;
  logic [IW-1:0] jj;

  // Scan from the farthest position back to last+1 so the nearest hit is written last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = N; k >= 1; k--) begin
      j  = (int'(last_i) + k) % N;
      jj = IW'(j);
      if (valid_i[jj]) begin
        grant_o     = '0;
        grant_o[jj] = 1'b1;
        idx_o       = jj;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters: round-robin accept, hold operands ALU_LAT cycles,
// return rd/z as a one-cycle pulse. Handshake: transfer when req_valid[i] & req_ready[i] in IDLE.
module alu_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ALU_LAT = 1,
  parameter int XLEN    = alu_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [3*N_REQ-1:0]    req_ctrl,
  input  logic [XLEN*N_REQ-1:0] req_a,
  input  logic [XLEN*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [XLEN-1:0]       rsp_rd,
  output logic                  rsp_z,
  output logic [2:0]            alu_ctrl,
  output logic [XLEN-1:0]       alu_rs1,
  output logic [XLEN-1:0]       alu_rs2,
  input  logic [XLEN-1:0]       alu_rd,
  input  logic                  alu_z,
  output alu_pkg::arb_state_e   dbg_state_o
);
  import alu_pkg::*;

  localparam int IW = $clog2(N_REQ);

  arb_state_e       state_q;
  logic [IW-1:0]    last_q;
  logic [IW-1:0]    grant_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       alu_ctrl_q;
  logic [XLEN-1:0]  rs1_q;
  logic [XLEN-1:0]  rs2_q;
  logic [XLEN-1:0]  rsp_rd_q;
  logic             rsp_z_q;
  logic [N_REQ-1:0] rsp_valid_q;

  logic [N_REQ-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             accept;

  rr_pick #(.N(N_REQ)) u_pick (
    .valid_i (req_valid),
    .last_i  (last_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Ready is the picker's one-hot, so any ready bit implies its valid: accept == handshake.
  assign accept    = (state_q == IDLE) && pick_any && !rst;
  assign req_ready = accept ? pick_grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IW'(N_REQ - 1);
      grant_q     <= '0;
      cnt_q       <= '0;
      alu_ctrl_q  <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rsp_rd_q    <= '0;
      rsp_z_q     <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_ctrl_q <= req_ctrl[3*int'(pick_idx) +: 3];
            rs1_q      <= req_a[XLEN*int'(pick_idx) +: XLEN];
            rs2_q      <= req_b[XLEN*int'(pick_idx) +: XLEN];
            grant_q    <= pick_idx;
            last_q     <= pick_idx;
            cnt_q      <= CNT_W'(ALU_LAT - 1);
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            rsp_rd_q    <= alu_rd;
            rsp_z_q     <= alu_z;
            rsp_valid_q <= N_REQ'(1) << grant_q;
            state_q     <= RESP;
          end
        end
        RESP: begin
          rsp_valid_q <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rd      = rsp_rd_q;
  assign rsp_z       = rsp_z_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign alu_rs1     = rs1_q;
  assign alu_rs2     = rs2_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU (ports clk, rs1, rs2, rd, z, ctrl) between N_REQ requesters, for example the execute stage and the branch/address unit.
- Accepts one operation at a time with a valid/ready handshake and uses round-robin priority.
- Drives the ALU operands from registers and holds them for ALU_LAT cycles.
- Captures rd and z and returns them to the winning requester as a one-cycle response pulse.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ALU_LAT, 1, cycles the ALU operands are held before rd/z are sampled (1..15). Use 1 for a combinational ALU and 2 for a registered ALU.
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  N_REQ  per-requester operation valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_ctrl  in  3*N_REQ  packed ALU op per requester; requester i uses bits [3i+2:3i].
- req_a  in  XLEN*N_REQ  packed rs1 operands.
- req_b  in  XLEN*N_REQ  packed rs2 operands.
- rsp_valid  out  N_REQ  one-hot response pulse to the granted requester.
- rsp_rd  out  XLEN  result, valid while any rsp_valid bit is high.
- rsp_z  out  1  ALU zero flag for the response.
- alu_ctrl  out  3  to ALU ctrl.
- alu_rs1  out  XLEN  to ALU rs1.
- alu_rs2  out  XLEN  to ALU rs2.
- alu_rd  in  XLEN  from ALU rd.
- alu_z  in  1  from ALU z.

Behaviour:
- Reset values:
  - state = IDLE.
  - req_ready = 0 and rsp_valid = 0.
  - rsp_rd = 0 and rsp_z = 0.
  - alu_ctrl, alu_rs1 and alu_rs2 = 0.
  - Latency counter = 0.
  - Round-robin pointer last = N_REQ-1, so requester 0 has highest priority first.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational. It is high only for the first valid requester found scanning from last+1 upward, wrapping modulo N_REQ.
  - req_ready is all-zero when no req_valid is high, and is all-zero in EXEC and RESP.
  - Handshake occurs in cycle T when req_valid[i] & req_ready[i].
  - At the edge ending T: latch req_ctrl/a/b of requester i into alu_ctrl/rs1/rs2; store grant = i; last = i; counter = ALU_LAT-1; go to EXEC.
- EXEC (cycles T+1 .. T+ALU_LAT):
  - ALU outputs are held stable.
  - While counter != 0, decrement it.
  - When counter == 0: capture alu_rd into rsp_rd and alu_z into rsp_z; set rsp_valid[grant] = 1; go to RESP.
- RESP (cycle T+ALU_LAT+1):
  - rsp_valid is high for exactly this one cycle; there is no response backpressure.
  - Next edge: rsp_valid = 0; go to IDLE.
  - rsp_rd and rsp_z hold their value until the next capture.
- Timing:
  - The earliest next accept is cycle T+ALU_LAT+2.
  - Throughput is 1 operation per ALU_LAT+2 cycles.
- ALU operand registers keep the last operation's values after completion. They change only on an accept or on reset.
- ctrl encodings are forwarded unmodified, including the unused codes 100, 110 and 111. The arbiter does not decode ops.
- Requester obligations:
  - Hold valid and payload stable until ready.
  - Dropping valid before ready is tolerated (no grant results), because the grant is same-cycle.
- Simultaneous valids: exactly one grant per accept. A losing requester keeps valid and wins the next IDLE cycle if it is next in round-robin order.
- Reset during EXEC or RESP: return to IDLE next cycle with all outputs at reset values. No response is issued for the aborted operation, and the pointer is reset.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - arb_state_e enum: IDLE, EXEC, RESP.
  - XLEN constant.
- One sub-module, rr_pick: combinational round-robin selector. It takes the valid vector and the pointer and returns a one-hot grant and its index. It is reused by future bus arbiters.

Test Plan:
- Req0 only, ctrl=000, a=20, b=30, ALU_LAT=1, combinational ALU:
  - req_ready[0] high in the valid cycle T.
  - alu_rs1=20 and alu_rs2=30 in T+1.
  - rsp_valid=01 and rsp_rd=50 in T+2, rsp_z=0.
- Req1 only, ctrl=001, a=8, b=3 -> rsp_valid=10, rsp_rd=5. Then ctrl=001, a=20, b=20 -> rsp_rd=0, rsp_z=1.
- Both valid every cycle:
  - req0 ctrl=101 a=20 b=30; req1 ctrl=010 a=20 b=30.
  - Grants alternate 0,1,0,1.
  - Responses alternate rsp_rd=1 and rsp_rd=20 (20&30).
  - Accepts are spaced exactly ALU_LAT+2 cycles apart.
- ALU_LAT=2 with a registered ALU model, ctrl=011, a=20, b=30:
  - rsp_rd=30 (20|30) in T+3.
  - req_ready stays low in T+1 through T+3 even with req_valid high.
- Assert rst in T+1 after accepting a=20, b=30, add:
  - No rsp_valid ever appears.
  - All outputs are 0 the cycle after rst.
  - After release, the first grant with both valid goes to req0.
